mux_tree_pipe: RTL and testbench

Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 selection stages, with valid/ready flow control on input and output. It generalises the team's fixed 4:1 tree to any power-of-two input count and data width. Registers between tree levels allow it to meet timing on wide or deep selects. It sits between parallel producers (register banks, channel buffers) and a single serial consumer.

---
 rtl/mux_tree_pipe_if.sv | 32 +++
 rtl/mux_tree_pipe.sv | 125 ++++++++++++
 tb/tb_mux_tree_pipe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mux_tree_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mux_tree_pipe_if                                                            |
// | Valid/ready bus bundle for mux_tree_pipe: parallel words in, one word out.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface mux_tree_pipe_if #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8
);
  localparam int LEVELS = $clog2(N_IN);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN*DATA_W-1:0]   in_data;
  logic [LEVELS-1:0]        in_sel;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [LEVELS-1:0]        out_sel;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mux_tree_pipe                                                               |
// | Pipelined N:1 binary mux tree with valid/ready flow control.                |
// | Define MUX_TREE_PIPE_EN for one register stage per tree level; otherwise    |
// | the tree is combinational with a single output register stage.             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mux_tree_pipe #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_tree_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(N_IN);

`ifdef MUX_TREE_PIPE_EN
  // All tree levels packed back to back: level k starts at word N_IN - (N_IN >> k).
  localparam int NW = N_IN - 1;

  logic [NW*DATA_W-1:0]          r_tree;
  logic [NW*DATA_W-1:0]          w_tree_nxt;
  logic [LEVELS-1:0][LEVELS-1:0] r_sel;
  logic [LEVELS-1:0][LEVELS-1:0] w_sel_nxt;
  logic [LEVELS-1:0]             r_v;
  logic [LEVELS-1:0]             w_v_nxt;
  logic [LEVELS-1:0]             w_acc;

  // Acceptance ripples back from the consumer so empty stages fill while downstream stalls.
  always_comb begin
    w_acc = '0;
    w_acc[LEVELS-1] = !r_v[LEVELS-1] || bus.out_ready;
    for (int k = LEVELS - 2; k >= 0; k--) begin
      w_acc[k] = !r_v[k] || w_acc[k+1];
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int CNT = N_IN >> (k + 1);
    localparam int OFS = N_IN - (N_IN >> k);

    logic [2*CNT*DATA_W-1:0] w_src;
    logic [LEVELS-1:0]       w_src_sel;
    logic                    w_src_v;

    if (k == 0) begin : g_head
      assign w_src     = bus.in_data;
      assign w_src_sel = bus.in_sel;
      assign w_src_v   = bus.in_valid;
    end else begin : g_body
      assign w_src     = r_tree[(N_IN - (N_IN >> (k - 1)))*DATA_W +: 2*CNT*DATA_W];
      assign w_src_sel = r_sel[k-1];
      assign w_src_v   = r_v[k-1];
    end

    for (genvar j = 0; j < CNT; j++) begin : g_pair
      assign w_tree_nxt[(OFS+j)*DATA_W +: DATA_W] =
        !w_acc[k]    ? r_tree[(OFS+j)*DATA_W +: DATA_W] :
        w_src_sel[k] ? w_src[(2*j+1)*DATA_W +: DATA_W]  :
                       w_src[(2*j)*DATA_W +: DATA_W];
    end

    assign w_sel_nxt[k] = w_acc[k] ? w_src_sel : r_sel[k];
    assign w_v_nxt[k]   = w_acc[k] ? w_src_v   : r_v[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tree <= '0;
      r_sel  <= '0;
      r_v    <= '0;
    end else begin
      r_tree <= w_tree_nxt;
      r_sel  <= w_sel_nxt;
      r_v    <= w_v_nxt;
    end
  end

  assign bus.in_ready  = w_acc[0];
  assign bus.out_valid = r_v[LEVELS-1];
  assign bus.out_data  = r_tree[(NW-1)*DATA_W +: DATA_W];
  assign bus.out_sel   = r_sel[LEVELS-1];

`else
  logic [N_IN*DATA_W-1:0] w_lvl;
  logic [DATA_W-1:0]      r_data;
  logic [LEVELS-1:0]      r_sel;
  logic                   r_v;
  logic                   w_acc;

  // In-place reduction: word j of a level only reads words 2j and 2j+1 of the level above.
  always_comb begin
    w_lvl = bus.in_data;
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < (N_IN >> (k + 1)); j++) begin
        w_lvl[j*DATA_W +: DATA_W] = bus.in_sel[k] ? w_lvl[(2*j+1)*DATA_W +: DATA_W]
                                                  : w_lvl[(2*j)*DATA_W +: DATA_W];
      end
    end
  end

  assign w_acc = !r_v || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
      r_v    <= 1'b0;
    end else if (w_acc) begin
      r_data <= w_lvl[DATA_W-1:0];
      r_sel  <= bus.in_sel;
      r_v    <= bus.in_valid;
    end
  end

  assign bus.in_ready  = w_acc;
  assign bus.out_valid = r_v;
  assign bus.out_data  = r_data;
  assign bus.out_sel   = r_sel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mux_tree_pipe                                                            |
// | Scoreboard bench for mux_tree_pipe (N_IN = 8, DATA_W = 8).                  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_mux_tree_pipe;
  localparam int DATA_W = 8;
  localparam int N_IN   = 8;
  localparam int LEVELS = 3;
`ifdef MUX_TREE_PIPE_EN
  localparam int LAT = 3;
  localparam int CAP = 3;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [LEVELS-1:0] sel;
    int                cyc;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    acc_cnt = 0;
  bit    chk_lat = 1'b0;
  bit    gap_mode = 1'b0;
  bit    have_last = 1'b0;
  int    last_cyc = 0;
  beat_t q[$];

  mux_tree_pipe_if #(.DATA_W(DATA_W), .N_IN(N_IN)) bus ();

  mux_tree_pipe #(.DATA_W(DATA_W), .N_IN(N_IN)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Transfers are sampled at the falling edge, i.e. exactly what the next rising edge commits.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{data: bus.in_data[bus.in_sel*DATA_W +: DATA_W], sel: bus.in_sel, cyc: cyc});
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check_eq("sb_has_beat", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          beat_t e;
          e = q.pop_front();
          check_eq("out_data", 32'(bus.out_data), 32'(e.data));
          check_eq("out_sel", 32'(bus.out_sel), 32'(e.sel));
          if (chk_lat) check_eq("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
        if (gap_mode && have_last) check_eq("stream_gap", 32'(cyc - last_cyc), 32'd1);
        last_cyc  = cyc;
        have_last = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < N_IN; w++) bus.in_data[w*DATA_W +: DATA_W] = 8'($urandom);
    bus.in_sel = 3'($urandom_range(0, N_IN - 1));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_drain"}, 32'(q.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rand_data();
    tick();
    tick();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'h00);
    check_eq("rst_out_sel", 32'(bus.out_sel), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) tick();
    check_eq("post_rst_idle", 32'(q.size()), 32'd0);

    // Select sweep with latency checking
    chk_lat = 1'b1;
    for (int w = 0; w < N_IN; w++) bus.in_data[w*DATA_W +: DATA_W] = 8'(8'hA0 + w);
    for (int i = 0; i < N_IN; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'(i);
      check_eq("sweep_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drain("sweep");
    chk_lat = 1'b0;

    // Streaming, back-to-back
    have_last = 1'b0;
    gap_mode  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      rand_data();
      check_eq("stream_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drain("stream");
    gap_mode = 1'b0;

    // Backpressure fills the pipe to capacity
    acc_cnt       = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      rand_data();
      tick();
    end
    check_eq("bp_accepted", 32'(acc_cnt), 32'(CAP));
    check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    drain("bp");

    // Bubble collapse
    acc_cnt       = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = ((i % 2) == 0);
      rand_data();
      tick();
    end
    check_eq("bubble_accepted", 32'(acc_cnt), 32'(CAP));
    check_eq("bubble_in_ready", 32'(bus.in_ready), 32'd0);
    drain("bubble");

    // Mid-stream reset flushes in-flight beats
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      rand_data();
      tick();
    end
    rst_n = 1'b0;
    q.delete();
    rand_data();
    tick();
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      rand_data();
      tick();
    end
    drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
